// File: rtl/led_chaser_pkg.sv
// Shared types and constants for the LED chaser reaction game.
// The LFSR taps encode x^16+x^14+x^13+x^11+1 for a right-shifting Galois register.
package led_chaser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PLAY,
        WON,
        LOST
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/chaser_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the target source; advances every clock.
// A zero seed is replaced by 1 so the register can never lock up.
module chaser_lfsr16
    import led_chaser_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_value
);

    localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= SAFE_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/led_chaser_core.sv
// Reaction-game engine: lights a one-hot target, scores edge-detected correct presses within a timeout.
// Optional LED_CHASER_SPEEDUP_EN shortens the per-round timeout by SPEEDUP_STEP per hit, floored at MIN_TIMEOUT.
module led_chaser_core
    import led_chaser_pkg::*;
#(
    parameter int          NUM_LEDS       = 4,
    parameter int          ROUNDS_TO_WIN  = 16,
    parameter int          TIMEOUT_CYCLES = 25_000_000,
    parameter logic [15:0] LFSR_SEED      = LFSR_DEFAULT_SEED,
    parameter int          SPEEDUP_STEP   = 1_000_000,
    parameter int          MIN_TIMEOUT    = 5_000_000
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start_game,
    input  logic [NUM_LEDS-1:0]                button,
    output logic [NUM_LEDS-1:0]                led,
    output logic                               game_over,
    output logic                               game_won,
    output logic [$clog2(ROUNDS_TO_WIN+1)-1:0] score
);

    localparam int TGT_W   = $clog2(NUM_LEDS);
    localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);
    localparam int SCORE_W = $clog2(ROUNDS_TO_WIN + 1);

`ifdef LED_CHASER_SPEEDUP_EN
    localparam logic [63:0] STEP_EFF  = 64'(SPEEDUP_STEP);
    localparam logic [63:0] FLOOR_EFF = 64'(MIN_TIMEOUT);
`else
    localparam logic [63:0] STEP_EFF  = 64'(SPEEDUP_STEP) * 64'd0;
    localparam logic [63:0] FLOOR_EFF = 64'(MIN_TIMEOUT) * 64'd0;
`endif

    state_t               r_state;
    logic [NUM_LEDS-1:0]  r_led;
    logic                 r_game_over;
    logic                 r_game_won;
    logic [SCORE_W-1:0]   r_score;
    logic [TMR_W-1:0]     r_timer;
    logic [TMR_W-1:0]     r_tmo_last;
    logic [TGT_W-1:0]     r_target;
    logic [NUM_LEDS-1:0]  r_button_q;

    logic [15:0]          w_lfsr;
    logic [TGT_W-1:0]     w_lfsr_mod;
    logic [TGT_W-1:0]     w_next_target;
    logic [NUM_LEDS-1:0]  w_next_onehot;
    logic [NUM_LEDS-1:0]  w_target_onehot;
    logic [NUM_LEDS-1:0]  w_press;
    logic [63:0]          w_dec;
    logic [63:0]          w_tmo;

    chaser_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .o_value(w_lfsr)
    );

    // A repeat of the previous target is bumped to the next LED so every round visibly changes.
    assign w_lfsr_mod    = TGT_W'(w_lfsr % 16'(NUM_LEDS));
    assign w_next_target = (w_lfsr_mod != r_target)            ? w_lfsr_mod :
                           (w_lfsr_mod == TGT_W'(NUM_LEDS - 1)) ? '0 :
                                                                  w_lfsr_mod + 1'b1;
    assign w_next_onehot   = NUM_LEDS'(1) << w_next_target;
    assign w_target_onehot = NUM_LEDS'(1) << r_target;
    assign w_press         = button & ~r_button_q;

    // Timeout for the coming round, kept wide so a large score*step cannot wrap below the floor.
    assign w_dec = 64'(r_score) * STEP_EFF;
    assign w_tmo = (64'(TIMEOUT_CYCLES) >= w_dec + FLOOR_EFF) ? 64'(TIMEOUT_CYCLES) - w_dec : FLOOR_EFF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_led       <= '0;
            r_game_over <= 1'b0;
            r_game_won  <= 1'b0;
            r_score     <= '0;
            r_timer     <= '0;
            r_tmo_last  <= TMR_W'(TIMEOUT_CYCLES - 1);
            r_target    <= '0;
            r_button_q  <= '0;
        end else begin
            r_button_q <= button;
            case (r_state)
                IDLE, WON, LOST: begin
                    if (start_game) begin
                        r_state     <= ARM;
                        r_score     <= '0;
                        r_target    <= w_next_target;
                        r_led       <= w_next_onehot;
                        r_game_over <= 1'b0;
                        r_game_won  <= 1'b0;
                    end
                end
                ARM: begin
                    // Release gate: a button held from the previous round can never score.
                    if (button == '0) begin
                        r_state    <= PLAY;
                        r_timer    <= '0;
                        r_tmo_last <= TMR_W'(w_tmo - 64'd1);
                    end
                end
                PLAY: begin
                    if (w_press == w_target_onehot) begin
                        r_score <= r_score + 1'b1;
                        if (r_score == SCORE_W'(ROUNDS_TO_WIN - 1)) begin
                            r_state     <= WON;
                            r_led       <= '1;
                            r_game_over <= 1'b1;
                            r_game_won  <= 1'b1;
                        end else begin
                            r_state  <= ARM;
                            r_target <= w_next_target;
                            r_led    <= w_next_onehot;
                        end
                    end else if ((w_press != '0) || (r_timer == r_tmo_last)) begin
                        r_state     <= LOST;
                        r_led       <= '0;
                        r_game_over <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_led   <= '0;
                end
            endcase
        end
    end

    assign led       = r_led;
    assign game_over = r_game_over;
    assign game_won  = r_game_won;
    assign score     = r_score;

endmodule

// File: tb/tb_led_chaser_core.sv
// Self-checking bench for led_chaser_core: vector table, directed corner sequences and a random run
// against a round-level reference model (timeouts follow LED_CHASER_SPEEDUP_EN when defined).
module tb_led_chaser_core;

    localparam int          N    = 4;
    localparam int          R    = 3;
    localparam int          T    = 20;
    localparam int          S    = 5;
    localparam int          M    = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_game;
    logic [N-1:0] button;
    logic [N-1:0] led;
    logic         game_over;
    logic         game_won;
    logic [1:0]   score;

    always #5 clk = ~clk;

    led_chaser_core #(
        .NUM_LEDS      (N),
        .ROUNDS_TO_WIN (R),
        .TIMEOUT_CYCLES(T),
        .LFSR_SEED     (SEED),
        .SPEEDUP_STEP  (S),
        .MIN_TIMEOUT   (M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_game(start_game),
        .button    (button),
        .led       (led),
        .game_over (game_over),
        .game_won  (game_won),
        .score     (score)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model (round level) ----------------
    typedef enum int {PH_IDLE, PH_ARM, PH_PLAY, PH_WON, PH_LOST} phase_t;
    phase_t       m_phase;
    int           m_target, m_score, m_waited, m_limit;
    logic [15:0]  m_lfsr;
    logic [N-1:0] m_prev;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int          exps [4] = '{16, 14, 13, 11};
        logic [15:0] mask = 16'h0000;
        foreach (exps[k]) mask[exps[k] - 1] = 1'b1;
        return v[0] ? ((v >> 1) ^ mask) : (v >> 1);
    endfunction

    function automatic int round_limit(input int hits);
`ifdef LED_CHASER_SPEEDUP_EN
        int t = T - hits * S;
        return (t > M) ? t : M;
`else
        return T + 0 * hits;
`endif
    endfunction

    function automatic int pick_target(input logic [15:0] lf, input int prev);
        int t = int'(lf) % N;
        return (t == prev) ? (t + 1) % N : t;
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_target = 0;
        m_score  = 0;
        m_waited = 0;
        m_limit  = T;
        m_lfsr   = SEED;
        m_prev   = '0;
    endtask

    task automatic model_step(input logic st, input logic [N-1:0] b);
        logic [N-1:0] press;
        press = b & ~m_prev;
        case (m_phase)
            PH_IDLE, PH_WON, PH_LOST: begin
                if (st) begin
                    m_phase  = PH_ARM;
                    m_score  = 0;
                    m_target = pick_target(m_lfsr, m_target);
                end
            end
            PH_ARM: begin
                if (b == '0) begin
                    m_phase  = PH_PLAY;
                    m_waited = 0;
                    m_limit  = round_limit(m_score);
                end
            end
            PH_PLAY: begin
                m_waited++;
                if (press == (N'(1) << m_target)) begin
                    m_score++;
                    if (m_score == R) m_phase = PH_WON;
                    else begin
                        m_phase  = PH_ARM;
                        m_target = pick_target(m_lfsr, m_target);
                    end
                end else if (press != '0) begin
                    m_phase = PH_LOST;
                end else if (m_waited == m_limit) begin
                    m_phase = PH_LOST;
                end
            end
            default: ;
        endcase
        m_prev = b;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    function automatic logic [N-1:0] model_led();
        case (m_phase)
            PH_ARM, PH_PLAY: return N'(1) << m_target;
            PH_WON:          return '1;
            default:         return '0;
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic st, input logic [N-1:0] b);
        reset      = rst;
        start_game = st;
        button     = b;
        if (rst) model_reset();
        else     model_step(st, b);
        @(posedge clk);
        #1;
        check("cycle_outputs", {24'd0, led, game_over, game_won, score},
              {24'd0, model_led(), (m_phase == PH_WON) || (m_phase == PH_LOST), m_phase == PH_WON, 2'(m_score)});
    endtask

    // ---------------- vector table ----------------
    typedef enum int {B_NONE, B_HIT, B_MISS, B_TWO} bkind_t;
    typedef enum int {L_ZERO, L_TGT, L_ONES} lkind_t;
    typedef struct {
        logic   start;
        bkind_t bk;
        lkind_t lk;
        logic   over;
        logic   won;
        int     sc;
    } vec_t;

    function automatic logic [N-1:0] btn_of(input bkind_t k);
        logic [N-1:0] hit  = N'(1) << m_target;
        logic [N-1:0] miss = N'(1) << ((m_target + 1) % N);
        case (k)
            B_HIT:   return hit;
            B_MISS:  return miss;
            B_TWO:   return hit | miss;
            default: return '0;
        endcase
    endfunction

    initial begin
        vec_t         tbl [$];
        logic [N-1:0] b;
        logic [N-1:0] exp_led;
        int           lim;
        int           wins;

        tbl.push_back('{1'b1, B_NONE, L_TGT,  1'b0, 1'b0, 0}); // IDLE -> ARM
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 0}); // -> PLAY
        tbl.push_back('{1'b0, B_HIT,  L_TGT,  1'b0, 1'b0, 1}); // hit -> ARM
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 1});
        tbl.push_back('{1'b0, B_HIT,  L_TGT,  1'b0, 1'b0, 2});
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 2});
        tbl.push_back('{1'b0, B_HIT,  L_ONES, 1'b1, 1'b1, 3}); // third hit wins
        tbl.push_back('{1'b0, B_HIT,  L_ONES, 1'b1, 1'b1, 3}); // presses ignored in WON
        tbl.push_back('{1'b1, B_NONE, L_TGT,  1'b0, 1'b0, 0}); // restart
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, B_MISS, L_ZERO, 1'b1, 1'b0, 0}); // wrong button
        tbl.push_back('{1'b1, B_NONE, L_TGT,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, B_HIT,  L_TGT,  1'b0, 1'b0, 0}); // held in ARM: no score
        tbl.push_back('{1'b0, B_HIT,  L_TGT,  1'b0, 1'b0, 0});
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 0}); // release -> PLAY
        tbl.push_back('{1'b0, B_HIT,  L_TGT,  1'b0, 1'b0, 1});
        tbl.push_back('{1'b0, B_NONE, L_TGT,  1'b0, 1'b0, 1});
        tbl.push_back('{1'b0, B_TWO,  L_ZERO, 1'b1, 1'b0, 1}); // two buttons -> LOST
        tbl.push_back('{1'b1, B_NONE, L_TGT,  1'b0, 1'b0, 0});

        // reset state
        reset      = 1'b1;
        start_game = 1'b0;
        button     = '0;
        model_reset();
        #1;
        check("reset_outputs", {24'd0, led, game_over, game_won, score}, 32'd0);
        cycle(1'b1, 1'b0, '0);
        check("reset_held", {24'd0, led, game_over, game_won, score}, 32'd0);
        $display("reset: led=%b over=%0b won=%0b score=%0d", led, game_over, game_won, score);

        foreach (tbl[i]) begin
            b = btn_of(tbl[i].bk);
            cycle(1'b0, tbl[i].start, b);
            exp_led = (tbl[i].lk == L_ZERO) ? '0 : (tbl[i].lk == L_ONES) ? '1 : (N'(1) << m_target);
            check($sformatf("vec%0d_led", i), 32'(led), 32'(exp_led));
            check($sformatf("vec%0d_flags", i), {30'd0, game_over, game_won}, {30'd0, tbl[i].over, tbl[i].won});
            check($sformatf("vec%0d_score", i), 32'(score), 32'(tbl[i].sc));
            $display("vec %0d: start=%0b btn=%b led=%b over=%0b won=%0b score=%0d",
                     i, tbl[i].start, b, led, game_over, game_won, score);
        end

        // timeout: no press -> LOST exactly on the limit cycle (state is ARM, score 0 here)
        cycle(1'b0, 1'b0, '0);
        lim = round_limit(0);
        for (int i = 1; i <= lim; i++) begin
            cycle(1'b0, 1'b0, '0);
            check($sformatf("tmo0_cyc%0d", i), 32'(game_over), 32'(i == lim));
        end
        $display("timeout round0: limit=%0d over=%0b", lim, game_over);

        // correct press on the final allowed cycle counts as a hit
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        for (int i = 1; i < lim; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, N'(1) << m_target);
        check("late_hit_score", 32'(score), 32'd1);
        check("late_hit_over", 32'(game_over), 32'd0);
        $display("late hit: score=%0d over=%0b", score, game_over);

        // second-round timeout (shortened when speed-up is built in)
        cycle(1'b0, 1'b0, '0);
        lim = round_limit(1);
        for (int i = 1; i <= lim; i++) begin
            cycle(1'b0, 1'b0, '0);
            check($sformatf("tmo1_cyc%0d", i), 32'(game_over), 32'(i == lim));
        end
        check("tmo1_score_held", 32'(score), 32'd1);
        $display("timeout round1: limit=%0d over=%0b score=%0d", lim, game_over, score);

        // asynchronous reset in the middle of PLAY
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, N'(1) << m_target);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        reset = 1'b1;
        #1;
        check("async_reset", {24'd0, led, game_over, game_won, score}, 32'd0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, '0);
        check("post_reset_arm_led", 32'(led), 32'(N'(1) << pick_target(SEED, 0)));
        $display("async reset: led=%b score=%0d", led, score);

        // random play against the model
        wins = 0;
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 45)      b = N'(1) << m_target;
            else if (r < 75) b = '0;
            else             b = N'($urandom_range(0, (1 << N) - 1));
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0, b);
            if (game_won && m_phase == PH_WON) wins++;
        end
        $display("random run: 4000 cycles, cycles spent in WON=%0d", wins);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
